// File: rtl/secded_keyed_decoder_if.sv
// Valid/ready stream bundle for the keyed SEC-DED decoder: codeword in, corrected word out.
// The master modport is the producer/consumer side and the slave modport is the decoder.
interface secded_keyed_decoder_if #(
  parameter int DATA_W = 32,
  parameter int P      = 6
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [P:0]        in_chk;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [P-1:0]      out_syn;
  logic              err_single;
  logic              err_double;

  modport master (
    output in_valid, in_data, in_chk, out_ready,
    input  in_ready, out_valid, out_data, out_syn, err_single, err_double
  );

  modport slave (
    input  in_valid, in_data, in_chk, out_ready,
    output in_ready, out_valid, out_data, out_syn, err_single, err_double
  );
endinterface

// File: rtl/secded_keyed_decoder.sv
// Two-stage SEC-DED (extended Hamming) decoder. The low NUM_KEY syndrome bits pass through
// key-programmed 2-input LUTs; the key is loaded serially and committed atomically.
module secded_keyed_decoder #(
  parameter int DATA_W  = 32,
  parameter int P       = 6,
  parameter int NUM_KEY = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  secded_keyed_decoder_if.slave  bus,
  input  logic                   key_start_i,
  input  logic                   key_shift_i,
  input  logic                   key_bit_i,
  output logic                   key_valid_o
);

  localparam int N     = DATA_W + P;
  localparam int KEY_W = 4 * NUM_KEY;
  localparam int CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  function automatic logic is_pow2(input int v);
    return (v & (v - 32'sd1)) == 32'sd0;
  endfunction

  function automatic int data_pos(input int idx);
    int pos;
    int cnt;
    pos = 32'sd0;
    cnt = -32'sd1;
    for (int p = 1; p <= N; p++) begin
      if (!is_pow2(p)) begin
        cnt = cnt + 32'sd1;
        if (cnt == idx) pos = p;
      end
    end
    return pos;
  endfunction

  function automatic logic parity_f(input logic [DATA_W+P:0] v);
    return ^v;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   key_sh_q, key_sh_d;
  logic [KEY_W-1:0]   key_act_q, key_act_d;
  logic               key_valid_q, key_valid_d;

  logic [P-1:0]       pos_s [DATA_W];
  logic [P-1:0]       a_s;
  logic [P-1:0]       syn_s;
  logic               par_s;

  logic               s1_valid_q;
  logic [DATA_W-1:0]  s1_data_q;
  logic [P-1:0]       s1_syn_q;
  logic               s1_par_q;

  logic               s2_valid_q;
  logic [DATA_W-1:0]  out_data_q;
  logic [P-1:0]       out_syn_q;
  logic               err_single_q;
  logic               err_double_q;

  logic               s2_adv_s, s1_adv_s, in_ready_s, accept_s;
  logic [DATA_W-1:0]  corr_data_s;
  logic               single_s, double_s;

  // Codeword position of each data bit, fixed at elaboration.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pos
    localparam int POS = data_pos(gi);
    assign pos_s[gi] = P'(POS);
  end

  // Data-only Hamming sums a_j over the incoming word.
  always_comb begin
    a_s = '0;
    for (int i = 0; i < DATA_W; i++) begin
      a_s = a_s ^ (pos_s[i] & {P{bus.in_data[i]}});
    end
  end

  for (genvar gj = 0; gj < P; gj++) begin : g_syn
    if (gj < NUM_KEY) begin : g_key
      logic [3:0] lut_s;
      assign lut_s      = key_act_q[4*gj +: 4];
      assign syn_s[gj]  = lut_s[{a_s[gj], bus.in_chk[gj]}];
    end else begin : g_plain
      assign syn_s[gj] = a_s[gj] ^ bus.in_chk[gj];
    end
  end

  assign par_s = parity_f({bus.in_data, bus.in_chk});

  // Handshake: a stage moves when the one after it is empty or being drained.
  assign s2_adv_s   = !s2_valid_q || bus.out_ready;
  assign s1_adv_s   = s1_valid_q && s2_adv_s;
  assign in_ready_s = (state_q != SHIFT) && (!s1_valid_q || s2_adv_s);
  assign accept_s   = bus.in_valid && in_ready_s;

  // Classify the stage-1 syndrome and flip the addressed data bit when correctable.
  always_comb begin
    corr_data_s = s1_data_q;
    single_s    = 1'b0;
    double_s    = 1'b0;
    if (s1_par_q) begin
      if ({1'b0, s1_syn_q} > (P+1)'(N)) begin
        double_s = 1'b1;
      end else begin
        single_s = 1'b1;
        for (int i = 0; i < DATA_W; i++) begin
          corr_data_s[i] = s1_data_q[i] ^ (pos_s[i] == s1_syn_q);
        end
      end
    end else begin
      double_s = (s1_syn_q != '0);
    end
  end

  // Key-load FSM next state; key_start takes priority over a same-cycle shift.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_sh_d    = key_sh_q;
    key_act_d   = key_act_q;
    key_valid_d = key_valid_q;
    case (state_q)
      IDLE: begin
        if (key_start_i) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (key_start_i) begin
          cnt_d = '0;
        end else if (key_shift_i) begin
          key_sh_d = {key_sh_q[KEY_W-2:0], key_bit_i};
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(KEY_W)) state_d = COMMIT;
          else                        state_d = SHIFT;
        end else begin
          state_d = SHIFT;
        end
      end
      COMMIT: begin
        key_act_d   = key_sh_q;
        key_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Key FSM and both pipeline stages; reset drops any in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      key_sh_q     <= '0;
      key_act_q    <= '0;
      key_valid_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      err_single_q <= 1'b0;
      err_double_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_sh_q    <= key_sh_d;
      key_act_q   <= key_act_d;
      key_valid_q <= key_valid_d;
      if (accept_s) begin
        s1_valid_q <= 1'b1;
        s1_data_q  <= bus.in_data;
        s1_syn_q   <= syn_s;
        s1_par_q   <= par_s;
      end else if (s1_adv_s) begin
        s1_valid_q <= 1'b0;
      end
      if (s2_adv_s) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q   <= corr_data_s;
          out_syn_q    <= s1_syn_q;
          err_single_q <= single_s;
          err_double_q <= double_s;
        end
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_syn    = out_syn_q;
  assign bus.err_single = err_single_q;
  assign bus.err_double = err_double_q;
  assign key_valid_o    = key_valid_q;

endmodule

// File: tb/tb_secded_keyed_decoder.sv
// Self-checking bench for secded_keyed_decoder: directed vector table, key-load and
// back-pressure sequences, and a randomized stream scored against a behavioural model.
module tb_secded_keyed_decoder;

  localparam int DATA_W  = 32;
  localparam int P       = 6;
  localparam int NUM_KEY = 4;
  localparam int N       = DATA_W + P;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  syn;
    logic        es;
    logic        ed;
  } res_t;

  typedef struct {
    logic [31:0] d;
    logic [6:0]  c;
    logic [31:0] exp_data;
    logic [5:0]  exp_syn;
    logic        exp_es;
    logic        exp_ed;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_start = 1'b0;
  logic key_shift = 1'b0;
  logic key_bit   = 1'b0;
  logic key_valid;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   rx_cnt = 0;
  bit   mon_en = 1'b0;
  bit   bp_en  = 1'b0;
  logic [15:0] key_model = 16'h0000;
  res_t exp_q[$];

  secded_keyed_decoder_if #(.DATA_W(DATA_W), .P(P)) bus ();

  secded_keyed_decoder #(.DATA_W(DATA_W), .P(P), .NUM_KEY(NUM_KEY)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .key_start_i (key_start),
    .key_shift_i (key_shift),
    .key_bit_i   (key_bit),
    .key_valid_o (key_valid)
  );

  always #5 clk = ~clk;

  // Data index i sits at i+1 shifted past every power-of-two slot at or below it.
  function automatic int dpos(input int i);
    int pos;
    pos = i + 1;
    for (int j = 0; j < P; j++) if ((1 << j) <= pos) pos++;
    return pos;
  endfunction

  function automatic logic [6:0] enc(input logic [31:0] d);
    int x;
    logic [6:0] c;
    x = 0;
    for (int i = 0; i < DATA_W; i++) if (d[i]) x = x ^ dpos(i);
    for (int j = 0; j < P; j++) c[j] = ((x >> j) & 1) != 0;
    c[6] = ^d ^ ^c[5:0];
    return c;
  endfunction

  function automatic res_t model(input logic [31:0] d, input logic [6:0] c, input logic [15:0] k);
    int   s;
    int   sy;
    int   aj;
    int   cj;
    logic par;
    res_t r;
    s = 0;
    for (int i = 0; i < DATA_W; i++) if (d[i]) s = s ^ dpos(i);
    for (int j = 0; j < P; j++) if (c[j]) s = s ^ (1 << j);
    par = ^d ^ ^c;
    sy = 0;
    for (int j = 0; j < P; j++) begin
      cj = c[j] ? 1 : 0;
      aj = ((s >> j) & 1) ^ cj;
      if (j < NUM_KEY) begin
        if (k[4*j + 2*aj + cj]) sy = sy | (1 << j);
      end else begin
        sy = sy | (s & (1 << j));
      end
    end
    r.data = d;
    r.syn  = sy[5:0];
    r.es   = 1'b0;
    r.ed   = 1'b0;
    if (!par) begin
      r.ed = (sy != 0);
    end else if (sy > N) begin
      r.ed = 1'b1;
    end else begin
      r.es = 1'b1;
      for (int i = 0; i < DATA_W; i++) if (dpos(i) == sy) r.data[i] = ~d[i];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every output transfer against the queued model result.
  always @(negedge clk) begin
    if (mon_en && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'd1, 64'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("stream_out", {24'd0, bus.out_data, bus.out_syn, bus.err_single, bus.err_double},
              {24'd0, e.data, e.syn, e.es, e.ed});
        rx_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    key_start = 1'b0;
    key_shift = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    exp_q.delete();
    key_model = 16'h0000;
  endtask

  task automatic send(input logic [31:0] d, input logic [6:0] c);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_chk   = c;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    else exp_q.push_back(model(d, c, key_model));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load_key(input logic [15:0] k, input bit restart, input bit chk_rise);
    key_start = 1'b1;
    @(posedge clk);
    #1;
    key_start = 1'b0;
    if (restart) begin
      repeat (5) begin
        key_shift = 1'b1;
        key_bit   = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      key_start = 1'b1;
      key_shift = 1'b1;
      key_bit   = 1'b1;
      @(posedge clk);
      #1;
      key_start = 1'b0;
    end
    for (int i = 15; i >= 0; i--) begin
      key_shift = 1'b1;
      key_bit   = k[i];
      @(negedge clk);
      check("in_ready_shift", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    key_shift = 1'b0;
    if (chk_rise) check("key_valid_in_commit", 64'(key_valid), 64'd0);
    @(posedge clk);
    #1;
    check("key_valid_after_commit", 64'(key_valid), 64'd1);
    key_model = k;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    bus.in_valid = 1'b1;
    bus.in_data  = v.d;
    bus.in_chk   = v.c;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_lat"},  64'(lat), 64'd2);
    check({name, "_data"}, 64'(bus.out_data), 64'(v.exp_data));
    check({name, "_syn"},  64'(bus.out_syn), 64'(v.exp_syn));
    check({name, "_flags"}, {62'd0, bus.err_single, bus.err_double}, {62'd0, v.exp_es, v.exp_ed});
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] base, input logic [31:0] df, input logic [6:0] cf,
                              input logic [31:0] ed_, input logic [5:0] es_, input logic s, input logic d2);
    vec_t v;
    v.d        = base ^ df;
    v.c        = enc(base) ^ cf;
    v.exp_data = ed_;
    v.exp_syn  = es_;
    v.exp_es   = s;
    v.exp_ed   = d2;
    return v;
  endfunction

  initial begin
    vec_t        vecs[8];
    vec_t        zv;
    logic [31:0] bw[4];
    logic [31:0] d;
    logic [6:0]  c;
    int          w;
    int          rx0;
    bit          r;

    vecs[0] = mk(32'hDEADBEEF, 32'h0,        7'h00, 32'hDEADBEEF, 6'd0,  1'b0, 1'b0);
    vecs[1] = mk(32'hDEADBEEF, 32'h20,       7'h00, 32'hDEADBEEF, 6'd10, 1'b1, 1'b0);
    vecs[2] = mk(32'hDEADBEEF, 32'h3,        7'h00, 32'hDEADBEEC, 6'd6,  1'b0, 1'b1);
    vecs[3] = mk(32'hDEADBEEF, 32'h0,        7'h40, 32'hDEADBEEF, 6'd0,  1'b1, 1'b0);
    vecs[4] = mk(32'h12345678, 32'h0,        7'h04, 32'h12345678, 6'd4,  1'b1, 1'b0);
    vecs[5] = mk(32'h12345678, 32'h80000000, 7'h00, 32'h12345678, 6'd38, 1'b1, 1'b0);
    vecs[6] = mk(32'h00000000, 32'h4,        7'h21, 32'h00000004, 6'd39, 1'b0, 1'b1);
    vecs[7] = mk(32'hFFFFFFFF, 32'h00010000, 7'h00, 32'hFFFFFFFF, 6'd22, 1'b1, 1'b0);
    zv      = mk(32'hDEADBEEF, 32'h1,        7'h00, 32'hDEADBEEE, 6'd0,  1'b1, 1'b0);

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_chk    = '0;
    bus.out_ready = 1'b1;
    do_reset();

    check("rst_in_ready",  64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data), 64'd0);
    check("rst_out_syn",   64'(bus.out_syn), 64'd0);
    check("rst_flags",     {62'd0, bus.err_single, bus.err_double}, 64'd0);
    check("rst_key_valid", 64'(key_valid), 64'd0);

    run_vec("zero_key", zv);

    // First key load while a word sits in stage 1; that word must use the zero key.
    mon_en = 1'b1;
    rx0 = rx_cnt;
    send(32'hCAFEF00D, enc(32'hCAFEF00D) ^ 7'h02);
    load_key(16'h6666, 1'b0, 1'b1);
    drain();
    check("s1_word_emerged", 64'(rx_cnt - rx0), 64'd1);
    mon_en = 1'b0;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-pressure: four words offered over five stalled cycles.
    mon_en = 1'b1;
    bw[0] = 32'h11111111;
    bw[1] = 32'h22222222;
    bw[2] = 32'h33333333;
    bw[3] = 32'h44444444;
    bus.out_ready = 1'b0;
    w = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (w < 4) begin
        bus.in_valid = 1'b1;
        bus.in_data  = bw[w];
        bus.in_chk   = enc(bw[w]);
      end
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
      if (r && w < 4) begin
        exp_q.push_back(model(bw[w], enc(bw[w]), key_model));
        w++;
      end
    end
    bus.in_valid = 1'b0;
    check("bp_accepted", 64'(w), 64'd2);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_out_hold", 64'(bus.out_data), 64'(bw[0]));
    rx0 = rx_cnt;
    bus.out_ready = 1'b1;
    for (int i = w; i < 4; i++) send(bw[i], enc(bw[i]));
    drain();
    check("bp_rx", 64'(rx_cnt - rx0), 64'd4);

    // Reload with restart and a start+shift collision, then random traffic on that key.
    load_key(16'h9999, 1'b1, 1'b0);
    for (int n = 0; n < 20; n++) begin
      d = $urandom;
      send(d, enc(d));
    end
    drain();
    load_key(16'h6666, 1'b0, 1'b0);
    bp_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      d = $urandom;
      c = enc(d);
      repeat ($urandom_range(0, 2)) begin
        int b;
        b = $urandom_range(0, N);
        if (b < 32) d[b] = ~d[b];
        else        c[b-32] = ~c[b-32];
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(d, c);
    end
    bp_en = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset in the middle of a key load.
    key_start = 1'b1;
    @(posedge clk);
    #1;
    key_start = 1'b0;
    repeat (7) begin
      key_shift = 1'b1;
      key_bit   = 1'b1;
      @(posedge clk);
      #1;
    end
    key_shift = 1'b0;
    do_reset();
    check("rst_shift_key_valid", 64'(key_valid), 64'd0);
    check("rst_shift_in_ready",  64'(bus.in_ready), 64'd1);
    check("rst_shift_out_valid", 64'(bus.out_valid), 64'd0);
    rx0 = rx_cnt;
    send(32'h0F0F1234, enc(32'h0F0F1234));
    send(32'hA5A5A5A5, enc(32'hA5A5A5A5) ^ 7'h01);
    drain();
    check("rst_shift_rx", 64'(rx_cnt - rx0), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
